rf_access_ctrl: RTL and testbench
=================================

# rf_access_ctrl

Access controller for the single-read, single-write general-purpose register file. It shares the one write port among `NUM_WR` writeback requesters with round-robin arbitration. It sequences the one read port to fetch two source operands (rs1, rs2) per decode request, returning them as one response. It sits between decode/writeback stages and the register file, and is the only block driving the register file's port signals.

## Interface
- `ADDR_WIDTH`, 5, register index width
- `DATA_WIDTH`, 32, register data width
- `NUM_WR`, 2, number of write requesters (≥1)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `rd_req_valid`  in  1  operand request valid
- `rd_req_ready`  out  1  controller can accept operand request
- `rd_rs1`, `rd_rs2`  in  ADDR_WIDTH  source register indices
- `rd_rsp_valid`  out  1  operands valid
- `rd_rsp_ready`  in  1  consumer accepts operands
- `rd_op1`, `rd_op2`  out  DATA_WIDTH  operand values
- `wr_valid`  in  NUM_WR  per-requester write valid
- `wr_ready`  out  NUM_WR  per-requester grant (one-hot or zero)
- `wr_addr`  in  NUM_WR*ADDR_WIDTH  packed destination indices, requester i at slice i
- `wr_data`  in  NUM_WR*DATA_WIDTH  packed write data
- `rf_wen`, `rf_waddr`, `rf_wdata`  out  1/ADDR_WIDTH/DATA_WIDTH  to register file write port
- `rf_raddr`  out  ADDR_WIDTH  to register file read port
- `rf_rdata`  in  DATA_WIDTH  combinational read data from register file

## Operation
- Read FSM has four states: IDLE, READ1, READ2 and RESP.
  - IDLE: `rd_req_ready`=1. On `rd_req_valid`, latch rs1/rs2 and go to READ1.
  - READ1: `rf_raddr`=rs1. Capture `rf_rdata` into op1 at the clock edge, then go to READ2.
  - READ2: `rf_raddr`=rs2. Capture op2, then go to RESP.
  - RESP: `rd_rsp_valid`=1. `rd_op1`/`rd_op2` are held stable until `rd_rsp_ready`, then return to IDLE.
  - `rd_req_ready`=0 in every state except IDLE.
- `rf_raddr` is 0 in IDLE and RESP.
- Index 0 always captures 0, independent of `rf_rdata`.
- Write arbiter is combinational round-robin.
  - `rr_ptr` is NUM_WR-wide modulo, reset 0.
  - The grant goes to the first valid requester searching from `rr_ptr` upward with wrap-around.
  - `wr_ready` is asserted only to the granted requester; `rf_wdata` is the granted slice.
  - `rf_wen` = grant exists AND granted address ≠ 0. A write to r0 is acknowledged but suppressed.
  - After a grant to requester g, `rr_ptr` ← (g+1) mod NUM_WR. With no grant, `rr_ptr` holds.
- The read and write sides are independent; one write and one read happen every cycle when both are active.
- Reset:
  - FSM → IDLE; op1/op2 → 0; `rd_rsp_valid`=0; `rf_raddr`=0; `rr_ptr`=0.
  - While `rst`=1: `wr_ready`=0 and `rf_wen`=0.
  - Reset mid-operation drops any in-flight request or response without emitting it.

## Timing
- Request handshake at edge T → READ1 during cycle T+1, READ2 during T+2, `rd_rsp_valid`=1 from T+3.
- Latency is 3 cycles. Best-case throughput is one request per 4 cycles (rsp_ready already high).
- The write grant and `rf_wen` are in the same cycle as `wr_valid`. The data is in the register file after that edge.
- A write to the address being read in the same cycle: the register file returns the old value, unless bypass is enabled (see Configuration).
- Requester i holds `wr_valid`/`wr_addr`/`wr_data` stable until `wr_ready[i]`.
- Consumer-side stall in RESP has no limit; the outputs stay held.

## Configuration
- `RF_CTRL_BYPASS_EN` defined:
  - In READ1/READ2, if `rf_wen` and `rf_waddr` == current `rf_raddr`, capture `rf_wdata` instead of `rf_rdata`.
  - The response then reflects all writes granted up to and including the capture cycle.
- Not defined: capture always uses `rf_rdata`. A same-cycle write is not seen.

## Structure
- Shared package `rf_ctrl_pkg` holds:
  - the read-FSM state enum (IDLE/READ1/READ2/RESP);
  - default width constants (5, 32).
- Sub-module `rr_arbiter`: a parameterised NUM_WR round-robin arbiter (valid vector in, one-hot grant out, pointer update on grant). It is reusable elsewhere.
- Operand sequencing and port muxing stay in `rf_access_ctrl`.

## Test plan
- Reset, then idle: `rd_req_ready`=1, `rd_rsp_valid`=0, `rf_wen`=0, `rf_raddr`=0, `rd_op1`/`rd_op2`=0.
- Write r3=0x11 via req0 and r7=0x22 via req1 on separate cycles. Then request rs1=3, rs2=7 with rsp_ready=1 → response at T+3: op1=0x11, op2=0x22. `rd_req_ready` is high again at T+4.
- Both requesters valid continuously, with distinct addresses → grants alternate 0,1,0,1, starting with 0 after reset. Each grant matches its `rf_waddr`/`rf_wdata`.
- Write r0=0xFFFF_FFFF → `wr_ready` asserted, `rf_wen`=0. Read rs1=0, rs2=0 → op1=op2=0.
- r5 holds 0xAA. Write r5=0xBB in the READ1 cycle of a request with rs1=5:
  - op1=0xBB with `RF_CTRL_BYPASS_EN` defined;
  - op1=0xAA without it.
- Hold rsp_ready=0 for 5 cycles in RESP → outputs stable, no new request accepted. Assert `rst` in READ2 of a later request → no response, FSM back in IDLE the next cycle.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared types and default widths for the register-file access controller.
// Holds the read-sequencer state encoding used by rf_access_ctrl.
package rf_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ1 = 2'd1,
        READ2 = 2'd2,
        RESP  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/rf_access_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or above the
// pointer (with wrap), then moves the pointer just past the winner.
module rr_arbiter
    import rf_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] grant_idx;
    int               cand;

    // Grants are suppressed while in reset so nothing is acknowledged.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        ptr_d       = ptr_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_valid && !rst && valid[IDX_W'(cand)]) begin
                grant_valid             = 1'b1;
                grant_idx               = IDX_W'(cand);
                grant[IDX_W'(cand)]     = 1'b1;
            end
        end
        if (grant_valid) begin
            ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_access_ctrl.sv
// Register-file port controller: round-robin shared write port and a
// two-read operand sequencer. Optional write-to-read bypass: RF_CTRL_BYPASS_EN.
module rf_access_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_WR     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rd_req_valid,
    output logic                         rd_req_ready,
    input  logic [ADDR_WIDTH-1:0]        rd_rs1,
    input  logic [ADDR_WIDTH-1:0]        rd_rs2,
    output logic                         rd_rsp_valid,
    input  logic                         rd_rsp_ready,
    output logic [DATA_WIDTH-1:0]        rd_op1,
    output logic [DATA_WIDTH-1:0]        rd_op2,
    input  logic [NUM_WR-1:0]            wr_valid,
    output logic [NUM_WR-1:0]            wr_ready,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    output logic                         rf_wen,
    output logic [ADDR_WIDTH-1:0]        rf_waddr,
    output logic [DATA_WIDTH-1:0]        rf_wdata,
    output logic [ADDR_WIDTH-1:0]        rf_raddr,
    input  logic [DATA_WIDTH-1:0]        rf_rdata
);

    logic [NUM_WR-1:0]     grant;
    logic                  grant_valid;

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] rs1_q, rs1_d;
    logic [ADDR_WIDTH-1:0] rs2_q, rs2_d;
    logic [DATA_WIDTH-1:0] op1_q, op1_d;
    logic [DATA_WIDTH-1:0] op2_q, op2_d;
    logic [DATA_WIDTH-1:0] cap_data;

    rr_arbiter #(
        .NUM_REQ (NUM_WR)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .valid       (wr_valid),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Writes to r0 are acknowledged to the requester but never reach the RF.
    always_comb begin
        wr_ready = grant;
        rf_waddr = '0;
        rf_wdata = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (grant[i]) begin
                rf_waddr = wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                rf_wdata = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        rf_wen = grant_valid && (rf_waddr != '0);
    end

    always_comb begin
        rf_raddr = '0;
        if (state_q == READ1) begin
            rf_raddr = rs1_q;
        end else if (state_q == READ2) begin
            rf_raddr = rs2_q;
        end
    end

    always_comb begin
        cap_data = rf_rdata;
`ifdef RF_CTRL_BYPASS_EN
        if (rf_wen && (rf_waddr == rf_raddr)) begin
            cap_data = rf_wdata;
        end
`else
`endif
        if (rf_raddr == '0) begin
            cap_data = '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        rd_req_ready = 1'b0;
        rd_rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                rd_req_ready = 1'b1;
                if (rd_req_valid) begin
                    rs1_d   = rd_rs1;
                    rs2_d   = rd_rs2;
                    state_d = READ1;
                end
            end
            READ1: begin
                op1_d   = cap_data;
                state_d = READ2;
            end
            READ2: begin
                op2_d   = cap_data;
                state_d = RESP;
            end
            RESP: begin
                rd_rsp_valid = 1'b1;
                if (rd_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
        end else begin
            state_q <= state_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
        end
    end

    assign rd_op1 = op1_q;
    assign rd_op2 = op2_q;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Self-checking bench for rf_access_ctrl with a behavioural register file;
// expected operands are queued at request time and popped at the response.
`timescale 1ns/1ps
module tb_rf_access_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             rd_req_valid;
    logic             rd_req_ready;
    logic [AW-1:0]    rd_rs1;
    logic [AW-1:0]    rd_rs2;
    logic             rd_rsp_valid;
    logic             rd_rsp_ready;
    logic [DW-1:0]    rd_op1;
    logic [DW-1:0]    rd_op2;
    logic [NW-1:0]    wr_valid;
    logic [NW-1:0]    wr_ready;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             rf_wen;
    logic [AW-1:0]    rf_waddr;
    logic [DW-1:0]    rf_wdata;
    logic [AW-1:0]    rf_raddr;
    logic [DW-1:0]    rf_rdata;

    int checks = 0;
    int failures = 0;

    logic [2*DW-1:0] exp_q[$];
    logic [2*DW-1:0] exp_item;

    logic [DW-1:0] rf_mem [0:31];

    always #5 clk = ~clk;

    rf_access_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_WR     (NW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_rs1       (rd_rs1),
        .rd_rs2       (rd_rs2),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_ready (rd_rsp_ready),
        .rd_op1       (rd_op1),
        .rd_op2       (rd_op2),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .rf_raddr     (rf_raddr),
        .rf_rdata     (rf_rdata)
    );

    // r0 returns garbage so the controller's forced-zero capture is visible.
    always @(posedge clk) begin
        if (rf_wen) rf_mem[rf_waddr] <= rf_wdata;
    end
    assign rf_rdata = (rf_raddr == '0) ? 32'hDEAD_BEEF : rf_mem[rf_raddr];

    task automatic test_reset();
        wr_valid = 2'b11;
        wr_addr  = {5'd6, 5'd4};
        wr_data  = {32'h66, 32'h44};
        @(negedge clk); #1;
        checks++; if (wr_ready !== 2'b00) begin failures++; $display("[TB] FAIL rst_wr_ready got=%b exp=00", wr_ready); end
        checks++; if (rf_wen !== 1'b0) begin failures++; $display("[TB] FAIL rst_rf_wen got=%b exp=0", rf_wen); end
        @(negedge clk);
        rst = 1'b0;
        wr_valid = '0;
        #1;
        checks++; if (rd_req_ready !== 1'b1) begin failures++; $display("[TB] FAIL idle_req_ready got=%b exp=1", rd_req_ready); end
        checks++; if (rd_rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_rsp_valid got=%b exp=0", rd_rsp_valid); end
        checks++; if (rf_wen !== 1'b0) begin failures++; $display("[TB] FAIL idle_rf_wen got=%b exp=0", rf_wen); end
        checks++; if (rf_raddr !== 5'd0) begin failures++; $display("[TB] FAIL idle_raddr got=%0d exp=0", rf_raddr); end
        checks++; if ({rd_op1, rd_op2} !== 64'h0) begin failures++; $display("[TB] FAIL idle_ops got=%h/%h exp=0/0", rd_op1, rd_op2); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        wr_valid = 2'b01; wr_addr[4:0] = 5'd3; wr_data[31:0] = 32'h11;
        #1;
        checks++; if (wr_ready !== 2'b01) begin failures++; $display("[TB] FAIL wr0_ready got=%b exp=01", wr_ready); end
        checks++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h11}) begin failures++; $display("[TB] FAIL wr0_port got=%b/%0d/%h exp=1/3/11", rf_wen, rf_waddr, rf_wdata); end
        @(negedge clk);
        wr_valid = 2'b10; wr_addr[9:5] = 5'd7; wr_data[63:32] = 32'h22;
        #1;
        checks++; if (wr_ready !== 2'b10) begin failures++; $display("[TB] FAIL wr1_ready got=%b exp=10", wr_ready); end
        checks++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h22}) begin failures++; $display("[TB] FAIL wr1_port got=%b/%0d/%h exp=1/7/22", rf_wen, rf_waddr, rf_wdata); end
        @(negedge clk);
        wr_valid = '0; rd_rsp_ready = 1'b1;
        rd_req_valid = 1'b1; rd_rs1 = 5'd3; rd_rs2 = 5'd7;
        exp_q.push_back({32'h11, 32'h22});
        #1;
        checks++; if (rd_req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rd_accept got=%b exp=1", rd_req_ready); end
        @(negedge clk);
        rd_req_valid = 1'b0;
        #1;
        checks++; if ({rd_req_ready, rf_raddr} !== {1'b0, 5'd3}) begin failures++; $display("[TB] FAIL rd_read1 got=%b/%0d exp=0/3", rd_req_ready, rf_raddr); end
        @(negedge clk); #1;
        checks++; if (rf_raddr !== 5'd7) begin failures++; $display("[TB] FAIL rd_read2 got=%0d exp=7", rf_raddr); end
        @(negedge clk); #1;
        checks++;
        if (rd_rsp_valid !== 1'b1 || exp_q.size() == 0) begin
            failures++; $display("[TB] FAIL rd_latency got=%b exp=1", rd_rsp_valid);
        end else begin
            exp_item = exp_q.pop_front();
            checks++; if ({rd_op1, rd_op2} !== exp_item) begin failures++; $display("[TB] FAIL rd_ops got=%h/%h exp=%h", rd_op1, rd_op2, exp_item); end
        end
        @(negedge clk); #1;
        checks++; if ({rd_req_ready, rd_rsp_valid} !== 2'b10) begin failures++; $display("[TB] FAIL rd_return got=%b/%b exp=1/0", rd_req_ready, rd_rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [NW-1:0] exp_g;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        wr_valid = 2'b11;
        wr_addr  = {5'd12, 5'd10};
        wr_data  = {32'hC0, 32'hA0};
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++; if (wr_ready !== exp_g) begin failures++; $display("[TB] FAIL rr_grant%0d got=%b exp=%b", k, wr_ready, exp_g); end
            checks++;
            if ({rf_wen, rf_waddr, rf_wdata} !== ((k % 2 == 0) ? {1'b1, 5'd10, 32'hA0} : {1'b1, 5'd12, 32'hC0})) begin
                failures++; $display("[TB] FAIL rr_port%0d got=%b/%0d/%h", k, rf_wen, rf_waddr, rf_wdata);
            end
            @(negedge clk);
        end
        wr_valid = '0;
    endtask

    task automatic test_r0();
        @(negedge clk);
        wr_valid = 2'b01; wr_addr[4:0] = 5'd0; wr_data[31:0] = 32'hFFFF_FFFF;
        #1;
        checks++; if (wr_ready !== 2'b01) begin failures++; $display("[TB] FAIL r0_ready got=%b exp=01", wr_ready); end
        checks++; if (rf_wen !== 1'b0) begin failures++; $display("[TB] FAIL r0_wen got=%b exp=0", rf_wen); end
        @(negedge clk);
        wr_valid = '0; rd_req_valid = 1'b1; rd_rs1 = 5'd0; rd_rs2 = 5'd0;
        exp_q.push_back(64'h0);
        @(negedge clk);
        rd_req_valid = 1'b0;
        #1;
        for (int c = 0; c < 8 && rd_rsp_valid !== 1'b1; c++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (rd_rsp_valid !== 1'b1 || exp_q.size() == 0) begin
            failures++; $display("[TB] FAIL r0_timeout got=%b exp=1", rd_rsp_valid);
        end else begin
            exp_item = exp_q.pop_front();
            checks++; if ({rd_op1, rd_op2} !== exp_item) begin failures++; $display("[TB] FAIL r0_ops got=%h/%h exp=%h", rd_op1, rd_op2, exp_item); end
        end
        @(negedge clk);
    endtask

    task automatic test_bypass();
        logic [DW-1:0] exp1;
`ifdef RF_CTRL_BYPASS_EN
        exp1 = 32'hBB;
`else
        exp1 = 32'hAA;
`endif
        @(negedge clk);
        wr_valid = 2'b01; wr_addr[4:0] = 5'd5; wr_data[31:0] = 32'hAA;
        @(negedge clk);
        wr_valid = '0; rd_req_valid = 1'b1; rd_rs1 = 5'd5; rd_rs2 = 5'd12;
        exp_q.push_back({exp1, 32'hC0});
        @(negedge clk);
        rd_req_valid = 1'b0;
        wr_valid = 2'b01; wr_data[31:0] = 32'hBB;
        #1;
        checks++; if ({rf_wen, rf_raddr, rf_waddr} !== {1'b1, 5'd5, 5'd5}) begin failures++; $display("[TB] FAIL byp_collide got=%b/%0d/%0d exp=1/5/5", rf_wen, rf_raddr, rf_waddr); end
        @(negedge clk);
        wr_valid = '0;
        @(negedge clk); #1;
        checks++;
        if (rd_rsp_valid !== 1'b1 || exp_q.size() == 0) begin
            failures++; $display("[TB] FAIL byp_latency got=%b exp=1", rd_rsp_valid);
        end else begin
            exp_item = exp_q.pop_front();
            checks++; if ({rd_op1, rd_op2} !== exp_item) begin failures++; $display("[TB] FAIL byp_ops got=%h/%h exp=%h", rd_op1, rd_op2, exp_item); end
        end
        @(negedge clk);
    endtask

    task automatic test_stall_and_reset();
        @(negedge clk);
        rd_rsp_ready = 1'b0; rd_req_valid = 1'b1; rd_rs1 = 5'd3; rd_rs2 = 5'd10;
        exp_q.push_back({32'h11, 32'hA0});
        @(negedge clk);
        rd_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (rd_rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_enter got=%b exp=1", rd_rsp_valid); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rd_req_valid = 1'b1; rd_rs1 = 5'd7; rd_rs2 = 5'd7;
            #1;
            checks++;
            if ({rd_rsp_valid, rd_req_ready, rd_op1, rd_op2} !== {1'b1, 1'b0, 32'h11, 32'hA0}) begin
                failures++; $display("[TB] FAIL stall_hold%0d got=%b/%b/%h/%h exp=1/0/11/a0", c, rd_rsp_valid, rd_req_ready, rd_op1, rd_op2);
            end
        end
        @(negedge clk);
        rd_req_valid = 1'b0; rd_rsp_ready = 1'b1;
        #1;
        checks++;
        if (rd_rsp_valid !== 1'b1 || exp_q.size() == 0) begin
            failures++; $display("[TB] FAIL stall_rsp got=%b exp=1", rd_rsp_valid);
        end else begin
            exp_item = exp_q.pop_front();
            checks++; if ({rd_op1, rd_op2} !== exp_item) begin failures++; $display("[TB] FAIL stall_ops got=%h/%h exp=%h", rd_op1, rd_op2, exp_item); end
        end
        @(negedge clk); #1;
        checks++; if ({rd_req_ready, rd_rsp_valid} !== 2'b10) begin failures++; $display("[TB] FAIL stall_release got=%b/%b exp=1/0", rd_req_ready, rd_rsp_valid); end
        @(negedge clk); #1;
        checks++; if (rf_raddr !== 5'd0) begin failures++; $display("[TB] FAIL stall_no_accept got=%0d exp=0", rf_raddr); end

        rd_req_valid = 1'b1; rd_rs1 = 5'd7; rd_rs2 = 5'd3;
        @(negedge clk);
        rd_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wr_valid = 2'b11; wr_addr = {5'd12, 5'd5}; wr_data = {32'h1, 32'h2};
        #1;
        checks++; if (rf_raddr !== 5'd3) begin failures++; $display("[TB] FAIL mid_read2 got=%0d exp=3", rf_raddr); end
        checks++; if ({wr_ready, rf_wen} !== 3'b000) begin failures++; $display("[TB] FAIL mid_rst_wr got=%b/%b exp=00/0", wr_ready, rf_wen); end
        @(negedge clk);
        rst = 1'b0; wr_valid = '0;
        #1;
        checks++;
        if ({rd_req_ready, rd_rsp_valid, rf_raddr, rd_op1, rd_op2} !== {1'b1, 1'b0, 5'd0, 64'h0}) begin
            failures++; $display("[TB] FAIL mid_rst_idle got=%b/%b/%0d/%h/%h exp=1/0/0/0/0", rd_req_ready, rd_rsp_valid, rf_raddr, rd_op1, rd_op2);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            checks++; if (rd_rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_drop%0d got=%b exp=0", c, rd_rsp_valid); end
        end
    endtask

    initial begin
        rst = 1'b1;
        rd_req_valid = 1'b0;
        rd_rs1 = '0;
        rd_rs2 = '0;
        rd_rsp_ready = 1'b1;
        wr_valid = '0;
        wr_addr = '0;
        wr_data = '0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_r0();
        test_bypass();
        test_stall_and_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("[TB] FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
